reg_op_sequencer: RTL

//  Sequences and shares the 4-bit control register (cl/ld/inc/dec/sr/sl datapath) between two requesters, A and B.

---
 rtl/reg_op_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/reg_op_sequencer.sv
// Shares the 4-bit control register between requesters A and B: arbitrates one command at a time
// and expands it into single-cycle register strobes, then pulses the owner's done with the final value.
module reg_op_sequencer #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 4,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [2:0]        a_op,
    input  logic [CNT_W-1:0]  a_cnt,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_fill,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [2:0]        b_op,
    input  logic [CNT_W-1:0]  b_cnt,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_fill,
    input  logic [DATA_W-1:0] reg_q,
    output logic              reg_cl,
    output logic              reg_ld,
    output logic              reg_inc,
    output logic              reg_dec,
    output logic              reg_sr,
    output logic              reg_sl,
    output logic [DATA_W-1:0] reg_in,
    output logic              reg_ir,
    output logic              reg_il,
    output logic              done_a,
    output logic              done_b,
    output logic [DATA_W-1:0] result,
    output logic              busy
);
    // state | meaning
    // IDLE  | arbitrate and accept one command
    // EXEC  | one register strobe per cycle until rem runs out
    // DONE  | pulse owner's done, capture reg_q
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_CLR  = 3'd1;
    localparam logic [2:0] OP_LOAD = 3'd2;
    localparam logic [2:0] OP_INC  = 3'd3;
    localparam logic [2:0] OP_DEC  = 3'd4;
    localparam logic [2:0] OP_SHR  = 3'd5;
    localparam logic [2:0] OP_SHL  = 3'd6;
    localparam logic [2:0] OP_ROR  = 3'd7;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              fill_q, fill_d;
    logic              owner_q, owner_d;
    logic              last_b_q, last_b_d;
    logic [DATA_W-1:0] result_q;

    logic              pick_a, pick_b;
    logic [2:0]        sel_op;
    logic [CNT_W-1:0]  sel_cnt;

    // last_b_q resets to 1 so A wins the first contested round
    assign pick_a  = a_valid && (!b_valid || (RR_EN == 1'b0) || last_b_q);
    assign pick_b  = b_valid && !pick_a;
    assign sel_op  = pick_a ? a_op  : b_op;
    assign sel_cnt = pick_a ? a_cnt : b_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_NOP;
            rem_q    <= '0;
            data_q   <= '0;
            fill_q   <= 1'b0;
            owner_q  <= 1'b0;
            last_b_q <= 1'b1;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rem_q    <= rem_d;
            data_q   <= data_d;
            fill_q   <= fill_d;
            owner_q  <= owner_d;
            last_b_q <= last_b_d;
            if (state_q == S_DONE)
                result_q <= reg_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rem_d    = rem_q;
        data_d   = data_q;
        fill_d   = fill_q;
        owner_d  = owner_q;
        last_b_d = last_b_q;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        case (state_q)
            S_IDLE: begin
                a_ready = pick_a;
                b_ready = pick_b;
                if (pick_a || pick_b) begin
                    op_d     = sel_op;
                    data_d   = pick_a ? a_data : b_data;
                    fill_d   = pick_a ? a_fill : b_fill;
                    owner_d  = pick_b;
                    last_b_d = pick_b;
                    if (sel_op == OP_NOP || (sel_op inside {OP_INC, OP_DEC, OP_SHR, OP_SHL, OP_ROR}
                                             && sel_cnt == '0)) begin
                        state_d = S_DONE;
                    end else if (sel_op == OP_CLR || sel_op == OP_LOAD) begin
                        rem_d   = CNT_W'(1);
                        state_d = S_EXEC;
                    end else begin
                        rem_d   = sel_cnt;
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                rem_d = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1))
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        reg_cl  = 1'b0;
        reg_ld  = 1'b0;
        reg_inc = 1'b0;
        reg_dec = 1'b0;
        reg_sr  = 1'b0;
        reg_sl  = 1'b0;
        reg_ir  = 1'b0;
        reg_il  = 1'b0;
        if (state_q == S_EXEC) begin
            case (op_q)
                OP_CLR:  reg_cl  = 1'b1;
                OP_LOAD: reg_ld  = 1'b1;
                OP_INC:  reg_inc = 1'b1;
                OP_DEC:  reg_dec = 1'b1;
                OP_SHR: begin
                    reg_sr = 1'b1;
                    reg_ir = fill_q;
                end
                OP_ROR: begin
                    reg_sr = 1'b1;
                    reg_ir = reg_q[0];
                end
                OP_SHL: begin
                    reg_sl = 1'b1;
                    reg_il = fill_q;
                end
                default: ;
            endcase
        end
    end

    assign reg_in = data_q;
    assign done_a = (state_q == S_DONE) && !owner_q;
    assign done_b = (state_q == S_DONE) && owner_q;
    // result shows the final value already in the done cycle, then holds it
    assign result = (state_q == S_DONE) ? reg_q : result_q;
    assign busy   = (state_q != S_IDLE);

endmodule
